sram_arbiter: RTL and testbench



---
 rtl/sram_arb_pkg.sv | 9 +
 rtl/sram_rd_tag_pipe.sv | 34 +++
 rtl/sram_arbiter.sv | 96 +++++++++
 tb/tb_sram_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: client ids, arbiter FSM states and default widths shared by the sram_arbiter files
package sram_arb_pkg;
  localparam int AW_DEF = 20;
  localparam int DW_DEF = 16;
  localparam int RD_LAT_DEF = 2;
  localparam int STARVE_DEF = 8;
  typedef enum logic [1:0] {CL_RD0, CL_RD1, CL_WR, CL_NONE} client_e;
  typedef enum logic [1:0] {IDLE, RD, WR, DRAIN} state_e;
endpackage

// File: rtl/sram_rd_tag_pipe.sv
// sram_rd_tag_pipe: RD_LAT-deep {valid, client} shift register of in-flight reads (in: push/push_id; out: empty, out_valid/out_id = oldest stage)
module sram_rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic [1:0] push_id,
  output logic       empty,
  output logic       out_valid,
  output logic [1:0] out_id
);
  logic [RD_LAT-1:0]      vld;
  logic [RD_LAT-1:0][1:0] id;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      vld <= '0;
      id <= '0;
    end else begin
      vld[0] <= push;
      id[0] <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        id[i] <= id[i-1];
      end
    end
  always_comb begin
    empty = ~|vld;
    out_valid = vld[RD_LAT-1];
    out_id = id[RD_LAT-1];
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: rd0/rd1/wr -> one SRAM command per cycle (in: client req/addr/data, mem_data_out; out: comb gnts, rd*_valid/data, mem_r_request/out_addr, mem_we/in_addr/data_in)
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rd0_req,
  input  logic [AW-1:0] rd0_addr,
  output logic          rd0_gnt,
  output logic          rd0_valid,
  output logic [DW-1:0] rd0_data,
  input  logic          rd1_req,
  input  logic [AW-1:0] rd1_addr,
  output logic          rd1_gnt,
  output logic          rd1_valid,
  output logic [DW-1:0] rd1_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          mem_r_request,
  output logic [AW-1:0] mem_out_addr,
  output logic          mem_we,
  output logic [AW-1:0] mem_in_addr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);
  localparam int AGW = $clog2(STARVE + 1);
  localparam logic [AGW-1:0] STV = AGW'(STARVE);
  state_e         state, state_nx;
  client_e        sel, rr;
  logic           ptr_wr, a1, aw, drain, empty, tag_v, ret_v;
  logic [1:0]     tag_id, ret_id;
  logic [AGW-1:0] age1, age_wr;
  logic [DW-1:0]  hold0, hold1;
  sram_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd0_gnt || rd1_gnt),
    .push_id   (rd0_gnt ? CL_RD0 : CL_RD1),
    .empty     (empty),
    .out_valid (tag_v),
    .out_id    (tag_id)
  );
  always_comb begin
    a1 = age1 == STV;
    aw = age_wr == STV;
    rr = rd1_req && wr_req ? (ptr_wr ? CL_WR : CL_RD1) : rd1_req ? CL_RD1 : wr_req ? CL_WR : CL_NONE;
    sel = a1 ^ aw ? (a1 ? CL_RD1 : CL_WR) : !a1 && rd0_req ? CL_RD0 : rr;
    drain = state == DRAIN;
    rd0_gnt = reset_n && !drain && sel == CL_RD0;
    rd1_gnt = reset_n && !drain && sel == CL_RD1;
    wr_gnt = reset_n && empty && (drain ? wr_req : sel == CL_WR);
    state_nx = rd0_gnt || rd1_gnt ? RD : wr_gnt ? WR : (drain ? !empty : sel == CL_WR) ? DRAIN : IDLE;
    mem_r_request = state == RD;
    mem_we = state == WR;
    rd0_valid = ret_v && ret_id == CL_RD0;
    rd1_valid = ret_v && ret_id == CL_RD1;
    rd0_data = rd0_valid ? mem_data_out : hold0;
    rd1_data = rd1_valid ? mem_data_out : hold1;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ptr_wr <= 1'b0;
      age1 <= '0;
      age_wr <= '0;
      ret_v <= 1'b0;
      ret_id <= '0;
      hold0 <= '0;
      hold1 <= '0;
      mem_out_addr <= '0;
      mem_in_addr <= '0;
      mem_data_in <= '0;
    end else begin
      state <= state_nx;
      ptr_wr <= rd1_gnt ? 1'b1 : wr_gnt ? 1'b0 : ptr_wr;
      age1 <= !rd1_req || rd1_gnt ? '0 : a1 ? age1 : age1 + 1'b1;
      age_wr <= !wr_req || wr_gnt ? '0 : aw ? age_wr : age_wr + 1'b1;
      ret_v <= tag_v;
      ret_id <= tag_id;
      if (rd0_valid) hold0 <= mem_data_out;
      if (rd1_valid) hold1 <= mem_data_out;
      if (rd0_gnt) mem_out_addr <= rd0_addr;
      else if (rd1_gnt) mem_out_addr <= rd1_addr;
      if (wr_gnt) begin
        mem_in_addr <= wr_addr;
        mem_data_in <= wr_data;
      end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random stimulus checked against a cycle-level reference model of the arbiter
module tb_sram_arbiter;
  localparam int AW = 20, DW = 16, RD_LAT = 2, STARVE = 8;
  logic clock = 1'b0, reset_n = 1'b0;
  logic rd0_req = 1'b0, rd1_req = 1'b0, wr_req = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [DW-1:0] wr_data = '0, mem_data_out = '0;
  logic rd0_gnt, rd0_valid, rd1_gnt, rd1_valid, wr_gnt, mem_r_request, mem_we;
  logic [DW-1:0] rd0_data, rd1_data, mem_data_in;
  logic [AW-1:0] mem_out_addr, mem_in_addr;
  sram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE(STARVE)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_r_request(mem_r_request), .mem_out_addr(mem_out_addr), .mem_we(mem_we),
    .mem_in_addr(mem_in_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  always #5 clock = ~clock;
  int vecs = 0, errs = 0;
  int n = 0, age1, agew;
  bit ptr_wr, drain, s_g0, s_g1, s_gw;
  typedef struct {int g; int c;} rd_t;
  rd_t q[$];
  logic e_rreq, e_we;
  logic [AW-1:0] e_oaddr, e_iaddr;
  logic [DW-1:0] e_din, e_h0, e_h1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    age1 = 0; agew = 0; ptr_wr = 0; drain = 0; q.delete();
    e_rreq = 0; e_we = 0; e_oaddr = '0; e_iaddr = '0; e_din = '0; e_h0 = '0; e_h1 = '0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 32'(|{rd0_gnt, rd0_valid, rd0_data, rd1_gnt, rd1_valid, rd1_data, wr_gnt,
                   mem_r_request, mem_out_addr, mem_we, mem_in_addr, mem_data_in}), 0);
  endtask
  // one clock cycle: predict from the arbitration rules, compare at negedge, advance the model
  task automatic step();
    int pick;
    bit busy, v0, v1;
    @(negedge clock);
    busy = 0;
    foreach (q[i]) if (n - q[i].g >= 1 && n - q[i].g <= RD_LAT) busy = 1;
    pick = -1;
    if (drain) begin
      if (!busy) begin
        drain = 0;
        if (wr_req) pick = 2;
      end
    end else begin
      if (age1 >= STARVE && agew >= STARVE) pick = ptr_wr ? 2 : 1;
      else if (age1 >= STARVE) pick = 1;
      else if (agew >= STARVE) pick = 2;
      else if (rd0_req) pick = 0;
      else if (rd1_req && wr_req) pick = ptr_wr ? 2 : 1;
      else if (rd1_req) pick = 1;
      else if (wr_req) pick = 2;
      if (pick == 2 && busy) begin
        drain = 1;
        pick = -1;
      end
    end
    v0 = 0; v1 = 0;
    if (q.size() > 0 && q[0].g + 1 + RD_LAT == n) begin
      if (q[0].c == 0) begin v0 = 1; e_h0 = mem_data_out; end
      else begin v1 = 1; e_h1 = mem_data_out; end
      void'(q.pop_front());
    end
    s_g0 = rd0_gnt; s_g1 = rd1_gnt; s_gw = wr_gnt;
    chk("rd0_gnt", rd0_gnt, pick == 0);
    chk("rd1_gnt", rd1_gnt, pick == 1);
    chk("wr_gnt", wr_gnt, pick == 2);
    chk("mem_r_request", mem_r_request, e_rreq);
    chk("mem_out_addr", mem_out_addr, e_oaddr);
    chk("mem_we", mem_we, e_we);
    chk("mem_in_addr", mem_in_addr, e_iaddr);
    chk("mem_data_in", mem_data_in, e_din);
    chk("rd0_valid", rd0_valid, v0);
    chk("rd1_valid", rd1_valid, v1);
    chk("rd0_data", rd0_data, e_h0);
    chk("rd1_data", rd1_data, e_h1);
    e_rreq = pick == 0 || pick == 1;
    e_we = pick == 2;
    if (pick == 0) e_oaddr = rd0_addr;
    if (pick == 1) e_oaddr = rd1_addr;
    if (pick == 2) begin e_iaddr = wr_addr; e_din = wr_data; end
    if (e_rreq) q.push_back('{n, pick});
    age1 = (!rd1_req || pick == 1) ? 0 : (age1 < STARVE ? age1 + 1 : STARVE);
    agew = (!wr_req || pick == 2) ? 0 : (agew < STARVE ? agew + 1 : STARVE);
    if (pick == 1) ptr_wr = 1;
    if (pick == 2) ptr_wr = 0;
    @(posedge clock);
    #1;
    n++;
  endtask
  task automatic test1();
    mem_data_out = 16'h1234; rd0_addr = 20'h00010; rd0_req = 1;
    step();
    chk("t1_gnt", s_g0, 1);
    rd0_req = 0;
    chk("t1_rreq", mem_r_request, 1);
    chk("t1_addr", mem_out_addr, 20'h00010);
    step(); step();
    chk("t1_valid", rd0_valid, 1);
    chk("t1_data", rd0_data, 16'h1234);
    step();
    chk("t1_valid_off", rd0_valid, 0);
  endtask
  initial begin
    int k, n1, nw;
    model_reset();
    rd0_req = 1; rd1_req = 1; wr_req = 1;
    @(posedge clock); #1;
    chk_zero("reset_outputs");
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    @(posedge clock); #1;
    reset_n = 1;
    step();
    test1();
    wr_req = 1; wr_addr = 20'h0FFFF; wr_data = 16'hBEEF;
    step();
    chk("t2_gnt", s_gw, 1);
    wr_req = 0;
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_in_addr, 20'h0FFFF);
    chk("t2_data", mem_data_in, 16'hBEEF);
    step();
    chk("t2_we_once", mem_we, 0);
    n1 = 0; nw = 0;
    rd1_req = 1; wr_req = 1; rd1_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
    repeat (24) begin
      mem_data_out = DW'($urandom);
      step();
      if (s_g1) begin n1++; rd1_addr = AW'($urandom); end
      if (s_gw) begin nw++; wr_addr = AW'($urandom); wr_data = DW'($urandom); end
    end
    chk("alt_rd1_grants", n1, 6);
    chk("alt_wr_grants", nw, 6);
    rd1_req = 0; wr_req = 0;
    repeat (5) step();
    rd0_req = 1; rd1_req = 1; rd0_addr = AW'($urandom); rd1_addr = AW'($urandom);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      mem_data_out = DW'($urandom);
      step();
      if (s_g0) rd0_addr = AW'($urandom);
      if (s_g1) k = i;
    end
    chk("starve_wait", k, 9);
    rd1_req = 0;
    step();
    chk("rd0_resume", s_g0, 1);
    rd0_req = 0;
    repeat (5) step();
    rd0_req = 1; rd0_addr = 20'h1; mem_data_out = 16'hA001;
    step();
    rd0_req = 0; rd1_req = 1; rd1_addr = 20'h2; mem_data_out = 16'hA002;
    step();
    rd1_req = 0; rd0_req = 1; rd0_addr = 20'h3; mem_data_out = 16'hA003;
    step();
    rd0_req = 0;
    for (int i = 0; i < 5; i++) begin
      mem_data_out = DW'(16'hB000 + i);
      step();
    end
    rd0_req = 1; rd0_addr = 20'h5;
    step();
    rd0_req = 0; rd1_req = 1; rd1_addr = 20'h6;
    step();
    rd1_req = 0; rd0_req = 1;
    reset_n = 0;
    #1;
    chk_zero("midrst_outputs");
    rd0_req = 0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
    model_reset();
    repeat (5) step();
    test1();
    repeat (400) begin
      if (!rd0_req && $urandom_range(0, 3) == 0) begin rd0_req = 1; rd0_addr = AW'($urandom); end
      if (!rd1_req && $urandom_range(0, 2) == 0) begin rd1_req = 1; rd1_addr = AW'($urandom); end
      if (!wr_req && $urandom_range(0, 2) == 0) begin wr_req = 1; wr_addr = AW'($urandom); wr_data = DW'($urandom); end
      mem_data_out = DW'($urandom);
      step();
      if (s_g0) rd0_req = 0;
      if (s_g1) rd1_req = 0;
      if (s_gw) wr_req = 0;
    end
    for (int i = 0; i < 100 && (rd0_req || rd1_req || wr_req); i++) begin
      mem_data_out = DW'($urandom);
      step();
      if (s_g0) rd0_req = 0;
      if (s_g1) rd1_req = 0;
      if (s_gw) wr_req = 0;
    end
    chk("final_drain", 32'({rd0_req, rd1_req, wr_req}), 0);
    rd0_req = 0; rd1_req = 0; wr_req = 0;
    repeat (6) begin
      mem_data_out = DW'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
